// File: rtl/trigger_response_gen.sv
// Start/end/form trigger responder: arms on start, waits for end, then holds form_o
// high for FORM_LEN cycles. Extra starts queue up to PEND_MAX; state changes on negedge clk1.
module trigger_response_gen #(
    parameter int FORM_LEN = 4,
    parameter int MAX_WAIT = 16,
    parameter int PEND_MAX = 7,
    parameter int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          dis_i,
    input  logic          start_i,
    input  logic          end_i,
    output logic          form_o,
    output logic          busy_o,
    output logic [PW-1:0] pending_o,
    output logic          timeout_o,
    output logic          ovf_o,
    output logic [15:0]   resp_cnt_o
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int FW = (FORM_LEN > 1) ? $clog2(FORM_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] waitCnt_q, waitCnt_d;
    logic [FW-1:0] formCnt_q, formCnt_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          form_q, form_d;
    logic          timeout_q, timeout_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   respCnt_q, respCnt_d;

    logic          push;
    logic          consume;
    logic          nextAvail;

    always_ff @(negedge clk1 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            formCnt_q <= '0;
            pending_q <= '0;
            form_q    <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            respCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            formCnt_q <= formCnt_d;
            pending_q <= pending_d;
            form_q    <= form_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
            respCnt_q <= respCnt_d;
        end
    end

    // A start arriving on the same edge that frees the engine is consumed directly,
    // so a push with a simultaneous pop leaves the queue depth unchanged.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        formCnt_d = formCnt_q;
        pending_d = pending_q;
        form_d    = form_q;
        timeout_d = 1'b0;
        ovf_d     = ovf_q;
        respCnt_d = respCnt_q;
        push      = start_i && (state_q != IDLE);
        nextAvail = (pending_q != '0) || push;
        consume   = 1'b0;

        if (dis_i) begin
            state_d   = IDLE;
            waitCnt_d = '0;
            formCnt_d = '0;
            pending_d = '0;
            form_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && end_i) begin
                        state_d   = RESP;
                        form_d    = 1'b1;
                        formCnt_d = '0;
                    end else if (start_i) begin
                        state_d   = ARMED;
                        waitCnt_d = '0;
                    end
                end
                ARMED: begin
                    if (end_i) begin
                        state_d   = RESP;
                        form_d    = 1'b1;
                        formCnt_d = '0;
                    end else if (waitCnt_q == WW'(MAX_WAIT - 1)) begin
                        timeout_d = 1'b1;
                        waitCnt_d = '0;
                        consume   = nextAvail;
                        state_d   = nextAvail ? ARMED : IDLE;
                    end else begin
                        waitCnt_d = waitCnt_q + WW'(1);
                    end
                end
                RESP: begin
                    if (formCnt_q == FW'(FORM_LEN - 1)) begin
                        form_d    = 1'b0;
                        formCnt_d = '0;
                        respCnt_d = respCnt_q + 16'd1;
                        waitCnt_d = '0;
                        consume   = nextAvail;
                        state_d   = nextAvail ? ARMED : IDLE;
                    end else begin
                        formCnt_d = formCnt_q + FW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (push && !consume) begin
                if (pending_q < PW'(PEND_MAX)) begin
                    pending_d = pending_q + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (consume && !push) begin
                pending_d = pending_q - PW'(1);
            end
        end
    end

    assign form_o     = form_q;
    assign busy_o     = (state_q != IDLE);
    assign pending_o  = pending_q;
    assign timeout_o  = timeout_q;
    assign ovf_o      = ovf_q;
    assign resp_cnt_o = respCnt_q;

endmodule

// File: tb/tb_trigger_response_gen.sv
// Directed bench for trigger_response_gen; inputs change and outputs are sampled
// 2 ns after each negedge, where the DUT updates.
module tb_trigger_response_gen;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        dis_i;
    logic        start_i;
    logic        end_i;
    logic        form_o;
    logic        busy_o;
    logic [2:0]  pending_o;
    logic        timeout_o;
    logic        ovf_o;
    logic [15:0] resp_cnt_o;

    int checks = 0;
    int errors = 0;

    trigger_response_gen #(
        .FORM_LEN(4),
        .MAX_WAIT(16),
        .PEND_MAX(7)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .dis_i     (dis_i),
        .start_i   (start_i),
        .end_i     (end_i),
        .form_o    (form_o),
        .busy_o    (busy_o),
        .pending_o (pending_o),
        .timeout_o (timeout_o),
        .ovf_o     (ovf_o),
        .resp_cnt_o(resp_cnt_o)
    );

    always #5 clk1 = ~clk1;

    task automatic applyStimulus(input logic s, input logic e, input logic d);
        start_i = s;
        end_i   = e;
        dis_i   = d;
        @(negedge clk1);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic f, input logic b, input int p,
                            input logic t, input logic o, input int c);
        checkOutput({tag, ".form"}, {31'd0, form_o}, {31'd0, f});
        checkOutput({tag, ".busy"}, {31'd0, busy_o}, {31'd0, b});
        checkOutput({tag, ".pending"}, {29'd0, pending_o}, p);
        checkOutput({tag, ".timeout"}, {31'd0, timeout_o}, {31'd0, t});
        checkOutput({tag, ".ovf"}, {31'd0, ovf_o}, {31'd0, o});
        checkOutput({tag, ".respCnt"}, {16'd0, resp_cnt_o}, c);
    endtask

    initial begin
        rst = 1'b1; dis_i = 1'b0; start_i = 1'b0; end_i = 1'b0;
        #3;
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // T1: start and end together from IDLE
        applyStimulus(1, 1, 0);
        checkAll("t1.enter", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t1.hold", {31'd0, form_o}, 32'd1);
        end
        applyStimulus(0, 0, 0);
        checkAll("t1.done", 0, 0, 0, 0, 0, 1);

        // T2: end three cycles after start
        applyStimulus(1, 0, 0);
        checkAll("t2.armed", 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkAll("t2.wait", 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0);
        checkAll("t2.resp", 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t2.hold", {31'd0, form_o}, 32'd1);
        end
        applyStimulus(0, 0, 0);
        checkAll("t2.done", 0, 0, 0, 0, 0, 2);

        // T3: no end, timeout on the 16th edge after the start
        applyStimulus(1, 0, 0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t3.noTimeout", {31'd0, timeout_o}, 32'd0);
            checkOutput("t3.noForm", {31'd0, form_o}, 32'd0);
        end
        applyStimulus(0, 0, 0);
        checkAll("t3.timeout", 0, 0, 0, 1, 0, 2);
        applyStimulus(0, 0, 0);
        checkAll("t3.pulseEnd", 0, 0, 0, 0, 0, 2);

        // T4: fill the queue past PEND_MAX, then service every entry
        applyStimulus(1, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("t4.fill", {29'd0, pending_o}, i);
            checkOutput("t4.noOvf", {31'd0, ovf_o}, 32'd0);
        end
        applyStimulus(1, 0, 0);
        checkAll("t4.ovf", 0, 1, 7, 0, 1, 2);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(0, 1, 0);
            checkOutput("t4.roundForm", {31'd0, form_o}, 32'd1);
            for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
            applyStimulus(0, 0, 0);
            checkAll("t4.roundEnd", 0, (r < 7), (r < 7) ? 6 - r : 0, 0, 1, 3 + r);
        end

        // Start+end on the last RESP edge: pop and push cancel, end is not reused
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkAll("pp.resp", 1, 1, 1, 0, 1, 10);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 0);
        checkAll("pp.last", 0, 1, 1, 0, 1, 11);
        applyStimulus(0, 0, 0);
        checkAll("pp.stillArmed", 0, 1, 1, 0, 1, 11);

        // T5: disable during RESP with three pending
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkAll("t5.resp", 1, 1, 3, 0, 1, 11);
        applyStimulus(0, 0, 1);
        checkAll("t5.dis", 0, 0, 0, 0, 1, 11);
        applyStimulus(0, 1, 0);
        checkAll("t5.endIgnored", 0, 0, 0, 0, 1, 11);

        // T6: asynchronous reset between edges while ARMED
        applyStimulus(1, 0, 0);
        checkAll("t6.armed", 0, 1, 0, 0, 1, 11);
        start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkAll("t6.rst", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        applyStimulus(0, 0, 0);
        checkAll("t6.after", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
